onewire_temp_slave: RTL and testbench

ONEWIRE_TEMP_SLAVE -- requirements
Module: onewire_temp_slave

---
 rtl/onewire_temp_slave.sv | 212 +++++++++++++++++++++
 tb/tb_onewire_temp_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_temp_slave.sv
// 1-Wire slave that behaves like a DS18B20 answering Skip ROM, Convert T and Read Scratchpad.
// All bus timing is counted in whole microsecond ticks derived from sys_clk.
module onewire_temp_slave #(
  parameter int CLK_MHZ = 50,
  parameter int CONV_US = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  inout  wire         dq,
  input  logic [15:0] temp_raw,
  output logic        conv_busy,
  output logic [7:0]  last_cmd,
  output logic        reset_seen,
  output logic        frame_err
);

  localparam int TW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int CW = $clog2(CONV_US + 1);

  localparam logic [7:0] CMD_SKIP = 8'hCC;
  localparam logic [7:0] CMD_CONV = 8'h44;
  localparam logic [7:0] CMD_READ = 8'hBE;
  localparam logic [8:0] RESET_US = 9'd480;
  localparam logic [4:0] SLOT_LAST = 5'd29;
  localparam logic [6:0] PWAIT_LAST = 7'd29;
  localparam logic [6:0] PDRV_LAST = 7'd119;
  localparam logic [6:0] SPAD_BITS = 7'd72;

  typedef enum logic [2:0] {
    IDLE, PRES_WAIT, PRES_DRIVE, ROM_CMD, FUNC_CMD, CONV_POLL, READ_SPAD, HALT
  } state_t;

  state_t          state_reg, state_next;
  logic            dq_s1, dq_s2, dq_d;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [8:0]      low_us;
  logic [6:0]      tmr;
  logic            slot_active;
  logic [4:0]      slot_us;
  logic            rd_drive;
  logic [6:0]      sr;
  logic [2:0]      bit_cnt;
  logic [6:0]      rd_idx;
  logic [CW-1:0]   conv_cnt;
  logic [7:0]      temp_lsb, temp_msb, crc_reg;

  logic            fall, rise, bus_reset;
  logic            write_state, read_state;
  logic            slot_start, slot_done, byte_done;
  logic [7:0]      rx_byte, spad_byte;
  logic            read_bit, drive;
  logic            cmd_conv, cmd_read, cmd_err;

  // CRC over the eight scratchpad bytes, byte 0 first, each byte LSB first.
  function automatic logic [7:0] spad_crc(input logic [15:0] t);
    logic [63:0] d;
    logic [7:0]  c;
    logic        fb;
    d = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, t};
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
    return c;
  endfunction

  assign dq = drive ? 1'b0 : 1'bz;

  assign tick      = (tick_cnt == TW'(CLK_MHZ - 1));
  assign fall      = dq_d & ~dq_s2;
  assign rise      = ~dq_d & dq_s2;
  assign bus_reset = rise & (low_us == RESET_US);
  assign rx_byte   = {dq_s2, sr};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus_reset) begin
      state_next = PRES_WAIT;
    end else begin
      case (state_reg)
        PRES_WAIT:  if (tick && tmr == PWAIT_LAST) state_next = PRES_DRIVE;
        PRES_DRIVE: if (tick && tmr == PDRV_LAST) state_next = ROM_CMD;
        ROM_CMD:    if (byte_done) state_next = (rx_byte == CMD_SKIP) ? FUNC_CMD : HALT;
        FUNC_CMD: begin
          if (cmd_conv)      state_next = CONV_POLL;
          else if (cmd_read) state_next = READ_SPAD;
          else if (cmd_err)  state_next = HALT;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    write_state = (state_reg == ROM_CMD) || (state_reg == FUNC_CMD);
    read_state  = (state_reg == CONV_POLL) || (state_reg == READ_SPAD);
    slot_start  = fall && !slot_active && (write_state || read_state);
    slot_done   = slot_active && tick && (slot_us == SLOT_LAST) && !bus_reset;
    byte_done   = slot_done && write_state && (bit_cnt == 3'd7);
    cmd_conv    = byte_done && (state_reg == FUNC_CMD) && (rx_byte == CMD_CONV);
    cmd_read    = byte_done && (state_reg == FUNC_CMD) && (rx_byte == CMD_READ);
    cmd_err     = byte_done && (((state_reg == ROM_CMD) && (rx_byte != CMD_SKIP)) ||
                  ((state_reg == FUNC_CMD) && (rx_byte != CMD_CONV) && (rx_byte != CMD_READ)));
    drive       = (state_reg == PRES_DRIVE) || rd_drive;
    case (rd_idx[6:3])
      4'd0:    spad_byte = temp_lsb;
      4'd1:    spad_byte = temp_msb;
      4'd2:    spad_byte = 8'h4B;
      4'd3:    spad_byte = 8'h46;
      4'd4:    spad_byte = 8'h7F;
      4'd5:    spad_byte = 8'hFF;
      4'd6:    spad_byte = 8'h0C;
      4'd7:    spad_byte = 8'h10;
      4'd8:    spad_byte = crc_reg;
      default: spad_byte = 8'hFF;
    endcase
    if (state_reg == CONV_POLL) read_bit = ~conv_busy;
    else if (rd_idx >= SPAD_BITS) read_bit = 1'b1;
    else read_bit = spad_byte[rd_idx[2:0]];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dq_s1 <= 1'b1;
      dq_s2 <= 1'b1;
      dq_d  <= 1'b1;
    end else begin
      dq_s1 <= dq;
      dq_s2 <= dq_s1;
      dq_d  <= dq_s2;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt    <= '0;
      low_us      <= '0;
      tmr         <= '0;
      slot_active <= 1'b0;
      slot_us     <= '0;
      rd_drive    <= 1'b0;
      sr          <= '0;
      bit_cnt     <= '0;
      rd_idx      <= '0;
      conv_busy   <= 1'b0;
      conv_cnt    <= '0;
      temp_lsb    <= 8'h50;
      temp_msb    <= 8'h05;
      crc_reg     <= 8'h1C;
      last_cmd    <= 8'h00;
      reset_seen  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + TW'(1);
      reset_seen <= bus_reset;
      frame_err  <= cmd_err;

      // Our own drive must not look like a master holding the bus low.
      if (dq_s2) low_us <= '0;
      else if (tick && !drive && low_us != RESET_US) low_us <= low_us + 9'd1;

      if (state_next != state_reg) tmr <= '0;
      else if (tick && (state_reg == PRES_WAIT || state_reg == PRES_DRIVE)) tmr <= tmr + 7'd1;

      if (bus_reset || slot_done) slot_active <= 1'b0;
      else if (slot_start) slot_active <= 1'b1;

      if (slot_start) slot_us <= '0;
      else if (slot_active && tick) slot_us <= slot_us + 5'd1;

      if (bus_reset || slot_done) rd_drive <= 1'b0;
      else if (slot_start && read_state && !read_bit) rd_drive <= 1'b1;

      if (bus_reset) begin
        bit_cnt <= '0;
      end else if (slot_done && write_state) begin
        sr      <= rx_byte[7:1];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (bus_reset || cmd_read) rd_idx <= '0;
      else if (slot_done && state_reg == READ_SPAD && rd_idx != SPAD_BITS) rd_idx <= rd_idx + 7'd1;

      if (cmd_conv || cmd_read) last_cmd <= rx_byte;

      if (cmd_conv) begin
        conv_busy <= 1'b1;
        conv_cnt  <= '0;
      end else if (conv_busy && tick) begin
        if (conv_cnt == CW'(CONV_US - 1)) begin
          conv_busy <= 1'b0;
          temp_lsb  <= temp_raw[7:0];
          temp_msb  <= temp_raw[15:8];
          crc_reg   <= spad_crc(temp_raw);
        end else begin
          conv_cnt <= conv_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_onewire_temp_slave.sv
`timescale 1ns/1ps
// Directed bench: the initial block plays the 1-Wire master against the slave at CLK_MHZ=2.
module tb_onewire_temp_slave;
  localparam int US = 1000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        m_drive = 1'b0;
  logic [15:0] temp_raw = 16'h0550;
  logic        conv_busy, reset_seen, frame_err;
  logic [7:0]  last_cmd;
  wire         dq;

  int  n_checks = 0;
  int  n_fail = 0;
  int  rs_count = 0;
  int  fe_count = 0;
  int  slave_low = 0;
  time busy_rise = 0;
  time busy_fall = 0;
  logic busy_d = 1'b0;

  assign dq = m_drive ? 1'b0 : 1'bz;
  pullup (dq);

  always #250 sys_clk = ~sys_clk;

  onewire_temp_slave #(.CLK_MHZ(2), .CONV_US(1000)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .dq         (dq),
    .temp_raw   (temp_raw),
    .conv_busy  (conv_busy),
    .last_cmd   (last_cmd),
    .reset_seen (reset_seen),
    .frame_err  (frame_err)
  );

  always @(posedge sys_clk) begin
    if (reset_seen) rs_count++;
    if (frame_err) fe_count++;
    if (!dq && !m_drive) slave_low++;
    if (conv_busy != busy_d) begin
      if (conv_busy) busy_rise = $time;
      else busy_fall = $time;
      busy_d = conv_busy;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Master reset pulse followed by presence-window checks.
  task automatic bus_reset(input string tag);
    int rs0;
    rs0 = rs_count;
    m_drive = 1'b1;
    #(500*US) m_drive = 1'b0;
    #(25*US)  check_eq({tag, "_pres_before"}, 32'(dq), 1);
    #(10*US)  check_eq({tag, "_pres_low_a"}, 32'(dq), 0);
    #(110*US) check_eq({tag, "_pres_low_b"}, 32'(dq), 0);
    #(12*US)  check_eq({tag, "_pres_after"}, 32'(dq), 1);
    check_eq({tag, "_reset_seen"}, 32'(rs_count - rs0), 1);
    #(43*US);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      m_drive = 1'b1;
      if (v[i]) begin
        #(5*US) m_drive = 1'b0;
        #(65*US);
      end else begin
        #(60*US) m_drive = 1'b0;
        #(10*US);
      end
    end
  endtask

  task automatic read_bit(output logic b);
    m_drive = 1'b1;
    #(3*US) m_drive = 1'b0;
    #(10*US) b = dq;
    #(57*US);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
    return c;
  endfunction

  initial begin
    logic [7:0] pwr [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
    logic [7:0] got [9];
    logic [7:0] v;
    logic [7:0] crc;
    logic       b;
    int         rs0, sl0, fe0, polls;
    time        dur;

    #(2*US) sys_rst_n = 1'b1;
    #(5*US);
    check_eq("rst_conv_busy", 32'(conv_busy), 0);
    check_eq("rst_last_cmd", 32'(last_cmd), 0);
    check_eq("rst_reset_seen", 32'(rs_count), 0);
    check_eq("rst_frame_err", 32'(fe_count), 0);
    check_eq("rst_dq", 32'(dq), 1);

    // A 300 us low is too short to be a bus reset.
    rs0 = rs_count;
    sl0 = slave_low;
    m_drive = 1'b1;
    #(300*US) m_drive = 1'b0;
    #(200*US);
    check_eq("short_low_reset_seen", 32'(rs_count - rs0), 0);
    check_eq("short_low_presence", 32'(slave_low - sl0), 0);

    // Power-on scratchpad readback.
    bus_reset("r1");
    write_byte(8'hCC);
    write_byte(8'hBE);
    check_eq("r1_last_cmd", 32'(last_cmd), 32'hBE);
    for (int i = 0; i < 9; i++) begin
      read_byte(v);
      check_eq($sformatf("r1_byte%0d", i), 32'(v), 32'(pwr[i]));
    end

    // Conversion with a new temperature, polled until done.
    temp_raw = 16'h0191;
    bus_reset("r2");
    write_byte(8'hCC);
    write_byte(8'h44);
    check_eq("conv_busy_start", 32'(conv_busy), 1);
    check_eq("conv_last_cmd", 32'(last_cmd), 32'h44);
    read_bit(b);
    check_eq("poll_first", 32'(b), 0);
    polls = 0;
    while (!b && polls < 40) begin
      read_bit(b);
      polls++;
    end
    check_eq("poll_done", 32'(b), 1);
    check_eq("conv_busy_end", 32'(conv_busy), 0);
    dur = busy_fall - busy_rise;
    check_eq("conv_len_1000us", 32'(dur >= 999*US && dur <= 1001*US), 1);

    bus_reset("r3");
    write_byte(8'hCC);
    write_byte(8'hBE);
    check_eq("r3_last_cmd", 32'(last_cmd), 32'hBE);
    crc = 8'h00;
    for (int i = 0; i < 9; i++) begin
      read_byte(got[i]);
      crc = crc_step(crc, got[i]);
    end
    check_eq("r3_temp_lsb", 32'(got[0]), 32'h91);
    check_eq("r3_temp_msb", 32'(got[1]), 32'h01);
    for (int i = 2; i < 8; i++) check_eq($sformatf("r3_byte%0d", i), 32'(got[i]), 32'(pwr[i]));
    check_eq("r3_crc_residue", 32'(crc), 0);

    // Unsupported ROM command halts the slave until the next reset.
    bus_reset("r4");
    fe0 = fe_count;
    write_byte(8'h33);
    check_eq("halt_frame_err", 32'(fe_count - fe0), 1);
    sl0 = slave_low;
    read_byte(v);
    check_eq("halt_read", 32'(v), 32'hFF);
    check_eq("halt_no_drive", 32'(slave_low - sl0), 0);
    check_eq("halt_last_cmd", 32'(last_cmd), 32'hBE);

    // Reset part-way through a read restarts the scratchpad at byte 0.
    bus_reset("r5");
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(v);
    check_eq("r5_byte0", 32'(v), 32'h91);
    read_byte(v);
    check_eq("r5_byte1", 32'(v), 32'h01);
    bus_reset("r6");
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(v);
    check_eq("r6_byte0", 32'(v), 32'h91);
    read_byte(v);
    check_eq("r6_byte1", 32'(v), 32'h01);

    // System reset during the presence pulse releases the bus at once.
    m_drive = 1'b1;
    #(500*US) m_drive = 1'b0;
    #(60*US) check_eq("async_pre_dq", 32'(dq), 0);
    sys_rst_n = 1'b0;
    #1 check_eq("async_release_dq", 32'(dq), 1);
    #(5*US) sys_rst_n = 1'b1;
    #(2*US);
    check_eq("async_conv_busy", 32'(conv_busy), 0);
    check_eq("async_last_cmd", 32'(last_cmd), 0);
    bus_reset("r7");
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(v);
    check_eq("r7_byte0", 32'(v), 32'h50);
    read_byte(v);
    check_eq("r7_byte1", 32'(v), 32'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
